// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches from imem with one request in flight,
// and feeds {valid, pc, instr} plus enable/flush to the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [XLEN-1:0]    if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               ifid_en_o,
  output logic               ifid_flush_o
);

  state_t             state;
  state_t             state_nx;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pc_nx;
  logic [XLEN-1:0]    pc_inc;
  logic [XLEN-1:0]    tgt;
  logic [INSTR_W-1:0] ibuf;
  logic [INSTR_W-1:0] ibuf_nx;
  logic               req;
  logic               valid;
  logic               owed;
  logic [INSTR_W-1:0] instr;

  assign pc_inc = pc + XLEN'(PC_STEP);
  assign tgt    = {redirect_pc_i[XLEN-1:2], 2'b00};

  // A killed request still owes a response that must be swallowed.
  always_comb begin
    owed = 1'b0;
    unique case (1'b1)
      state == S_REQ:   owed = imem_gnt_i;
      state == S_WAIT:  owed = !imem_rvalid_i;
      state == S_DRAIN: owed = !imem_rvalid_i;
      default:          owed = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ibuf_nx  = ibuf;
    req      = 1'b0;
    valid    = 1'b0;
    instr    = ibuf;
    unique case (state)
      S_IDLE: begin
        state_nx = S_REQ;
      end
      S_REQ: begin
        req = 1'b1;
        if (imem_gnt_i) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          valid   = 1'b1;
          instr   = imem_rdata_i;
          ibuf_nx = imem_rdata_i;
          if (stall_i) begin
            state_nx = S_HOLD;
          end else begin
            pc_nx    = pc_inc;
            state_nx = S_REQ;
          end
        end
      end
      S_HOLD: begin
        valid = 1'b1;
        if (!stall_i) begin
          pc_nx    = pc_inc;
          state_nx = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) begin
          state_nx = S_REQ;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (redirect_i) begin
      valid    = 1'b0;
      pc_nx    = tgt;
      ibuf_nx  = NOP_INSTR;
      state_nx = owed ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ibuf  <= NOP_INSTR;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ibuf  <= ibuf_nx;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = pc;
  assign if_valid_o   = valid;
  assign if_pc_o      = pc;
  assign if_instr_o   = instr;
  assign ifid_en_o    = !stall_i;
  assign ifid_flush_o = redirect_i | (!valid & !stall_i);

endmodule
